// File: rtl/kpn_bcd_formatter_if.sv
// rtl/kpn_bcd_formatter_if.sv - FIFO-pop and character-stream signals of the BCD formatter
// slave is the formatter side; master is the FIFO/LCD-writer environment side.
interface kpn_bcd_formatter_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  fifo_empty;
   logic                  rd;
   logic [DATA_WIDTH-1:0] entry_1;
   logic [7:0]            char_out;
   logic                  char_valid;
   logic                  char_ready;
   logic                  token_done;
   logic                  busy;

   modport slave (
      input  fifo_empty, entry_1, char_ready,
      output rd, char_out, char_valid, token_done, busy
   );

   modport master (
      output fifo_empty, entry_1, char_ready,
      input  rd, char_out, char_valid, token_done, busy
   );
endinterface

// File: rtl/kpn_bcd_formatter.sv
// rtl/kpn_bcd_formatter.sv - pops one token, double-dabbles it, streams right-aligned ASCII digits
// The BCD register shifts left by one nibble per accepted character, so the current digit is always the top nibble.
module kpn_bcd_formatter #(
   parameter int DATA_WIDTH    = 16,
   parameter int DIGITS        = 5,
   parameter int BLANK_LEADING = 1
) (
   input logic               clk,
   input logic               rst_n,
   kpn_bcd_formatter_if.slave io
);
   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(DATA_WIDTH + 1);
   localparam int DIG_W = $clog2(DIGITS + 1);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_WIDTH - 1);
   localparam logic [DIG_W-1:0] DIG_ALL   = DIG_W'(DIGITS);
   localparam logic [DIG_W-1:0] DIG_ONE   = DIG_W'(1);
   localparam logic [DIG_W-1:0] DIG_TWO   = DIG_W'(2);

   typedef enum logic [2:0] {IDLE, READ, LATCH, CONV, EMIT, DONE} state_t;

   state_t                state_q;
   logic [DATA_WIDTH-1:0] shift_q;
   logic [BCD_W-1:0]      bcd_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [DIG_W-1:0]      dig_q;
   logic                  seen_q;
   logic                  rd_q;
   logic                  char_valid_q;
   logic [7:0]            char_out_q;
   logic                  token_done_q;
   logic                  busy_q;

   logic [BCD_W-1:0]      bcd_adj;
   logic [BCD_W-1:0]      conv_bcd_d;
   logic [3:0]            cur_digit;
   logic [3:0]            next_digit;
   logic                  seen_d;

   // seen: a non-zero digit has already gone out, so zeros from here on are numeric
   function automatic logic [7:0] encode(input logic [3:0] d, input logic seen, input logic lsd);
      if (BLANK_LEADING != 0 && d == 4'd0 && !seen && !lsd) return 8'h20;
      return {4'h3, d};
   endfunction

   always_comb begin
      bcd_adj = bcd_q;
      for (int k = 0; k < DIGITS; k++) begin
         if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
      conv_bcd_d = BCD_W'({bcd_adj, shift_q[DATA_WIDTH-1]});
      cur_digit  = bcd_q[BCD_W-1 -: 4];
      next_digit = bcd_q[BCD_W-5 -: 4];
      seen_d     = seen_q | (cur_digit != 4'd0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         shift_q      <= '0;
         bcd_q        <= '0;
         cnt_q        <= '0;
         dig_q        <= '0;
         seen_q       <= 1'b0;
         rd_q         <= 1'b0;
         char_valid_q <= 1'b0;
         char_out_q   <= 8'h00;
         token_done_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         rd_q         <= 1'b0;
         token_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!io.fifo_empty) begin
                  state_q <= READ;
                  rd_q    <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            READ: state_q <= LATCH;
            LATCH: begin
               shift_q <= io.entry_1;
               bcd_q   <= '0;
               cnt_q   <= '0;
               state_q <= CONV;
            end
            CONV: begin
               shift_q <= shift_q << 1;
               bcd_q   <= conv_bcd_d;
               if (cnt_q == LAST_ITER) begin
                  state_q      <= EMIT;
                  dig_q        <= DIG_ALL;
                  seen_q       <= 1'b0;
                  char_valid_q <= 1'b1;
                  char_out_q   <= encode(conv_bcd_d[BCD_W-1 -: 4], 1'b0, DIGITS == 1);
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            EMIT: begin
               if (io.char_ready) begin
                  if (dig_q == DIG_ONE) begin
                     state_q      <= DONE;
                     char_valid_q <= 1'b0;
                     token_done_q <= 1'b1;
                  end else begin
                     bcd_q      <= bcd_q << 4;
                     dig_q      <= dig_q - 1'b1;
                     seen_q     <= seen_d;
                     char_out_q <= encode(next_digit, seen_d, dig_q == DIG_TWO);
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign io.rd         = rd_q;
   assign io.char_out   = char_out_q;
   assign io.char_valid = char_valid_q;
   assign io.token_done = token_done_q;
   assign io.busy       = busy_q;
endmodule

// File: tb/tb_kpn_bcd_formatter.sv
// tb/tb_kpn_bcd_formatter.sv - directed vector bench for kpn_bcd_formatter
// Two instances share stimulus: dut1 blanks leading zeros, dut0 prints them as '0'.
module tb_kpn_bcd_formatter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        fe;
   logic [15:0] data;
   logic        cr;

   always #5 clk = ~clk;

   kpn_bcd_formatter_if #(.DATA_WIDTH(16)) if1 ();
   kpn_bcd_formatter_if #(.DATA_WIDTH(16)) if0 ();

   assign if1.fifo_empty = fe;
   assign if1.entry_1    = data;
   assign if1.char_ready = cr;
   assign if0.fifo_empty = fe;
   assign if0.entry_1    = data;
   assign if0.char_ready = cr;

   kpn_bcd_formatter #(.DATA_WIDTH(16), .DIGITS(5), .BLANK_LEADING(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .io(if1.slave));
   kpn_bcd_formatter #(.DATA_WIDTH(16), .DIGITS(5), .BLANK_LEADING(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .io(if0.slave));

   typedef struct {
      logic [15:0] val;
      bit          rand_cr;
      logic [39:0] exp1;
      logic [39:0] exp0;
   } vec_t;

   vec_t        vecs[10];
   int          pass_cnt = 0;
   int          total = 0;
   int          cyc = 0;
   int          rd_cnt = 0;
   int          done_cnt = 0;
   int          first_cv = -1;
   int          last_done = -1;
   bit          prev_stall = 1'b0;
   logic [7:0]  prev_char = 8'h00;
   logic [15:0] fifo[$];
   logic [7:0]  got1[$];
   logic [7:0]  got0[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Observes the cycle just ending, steps one clock, then plays the FIFO side.
   task automatic tick();
      bit was_rd;
      was_rd = if1.rd;
      if (if1.rd) begin
         chk("rd_after_done", 64'(done_cnt), 64'(rd_cnt));
         rd_cnt++;
      end
      if (prev_stall) begin
         chk("hold_valid", 64'(if1.char_valid), 64'd1);
         chk("hold_char", 64'(if1.char_out), 64'(prev_char));
      end
      prev_stall = if1.char_valid && !cr;
      prev_char  = if1.char_out;
      if (if1.char_valid && first_cv < 0) first_cv = cyc;
      if (if1.char_valid && cr) got1.push_back(if1.char_out);
      if (if0.char_valid && cr) got0.push_back(if0.char_out);
      if (if1.token_done) begin
         done_cnt++;
         last_done = cyc;
      end
      @(posedge clk);
      #1;
      if (was_rd && fifo.size() > 0) data = fifo.pop_front();
      fe = (fifo.size() == 0);
      cyc++;
   endtask

   task automatic clear_obs();
      got1.delete();
      got0.delete();
      rd_cnt     = 0;
      done_cnt   = 0;
      first_cv   = -1;
      last_done  = -1;
      prev_stall = 1'b0;
   endtask

   task automatic wait_done(input int target, input bit rnd);
      int budget = 0;
      while (done_cnt < target && budget < 400) begin
         if (rnd) cr = 1'($urandom_range(0, 1));
         tick();
         budget++;
      end
      cr = 1'b1;
      chk("done_timeout", 64'(done_cnt), 64'(target));
   endtask

   function automatic logic [39:0] pack(input bit which, input int start);
      logic [39:0] v = '0;
      for (int i = 0; i < 5; i++) begin
         if (which && start + i < got1.size()) v = {v[31:0], got1[start+i]};
         else if (!which && start + i < got0.size()) v = {v[31:0], got0[start+i]};
         else v = {v[31:0], 8'hxx};
      end
      return v;
   endfunction

   task automatic run_one(input vec_t v);
      int t;
      clear_obs();
      cr = 1'b1;
      t  = cyc;
      fifo.push_back(v.val);
      fe = 1'b0;
      tick();
      chk("rd_pulse", 64'(if1.rd), 64'd1);
      chk("busy_set", 64'(if1.busy), 64'd1);
      wait_done(1, v.rand_cr);
      if (!v.rand_cr) begin
         chk("first_char_latency", 64'(first_cv - t), 64'd19);
         chk("token_done_latency", 64'(last_done - t), 64'd24);
      end
      chk("nchars_blank", 64'(got1.size()), 64'd5);
      chk("nchars_zero", 64'(got0.size()), 64'd5);
      chk("text_blank", 64'(pack(1'b1, 0)), 64'(v.exp1));
      chk("text_zero", 64'(pack(1'b0, 0)), 64'(v.exp0));
      repeat (3) tick();
      chk("busy_idle", 64'(if1.busy), 64'd0);
      chk("single_rd", 64'(rd_cnt), 64'd1);
   endtask

   // Drops reset mid-cycle and checks the outputs clear without waiting for a clock edge.
   task automatic abort_now(input string tag);
      #2 rst_n = 1'b0;
      #1;
      chk({tag, "_valid"}, 64'(if1.char_valid), 64'd0);
      chk({tag, "_char"}, 64'(if1.char_out), 64'h00);
      chk({tag, "_busy"}, 64'(if1.busy | if0.busy), 64'd0);
      chk({tag, "_rd_done"}, 64'(if1.rd | if1.token_done), 64'd0);
      prev_stall = 1'b0;
      tick();
      rst_n = 1'b1;
      clear_obs();
      cr = 1'b1;
      repeat (40) tick();
      chk({tag, "_no_emit"}, 64'(got1.size() + got0.size() + rd_cnt), 64'd0);
   endtask

   initial begin
      int bad;
      vecs[0] = '{16'd1234,  1'b0, " 1234", "01234"};
      vecs[1] = '{16'd0,     1'b0, "    0", "00000"};
      vecs[2] = '{16'd65535, 1'b0, "65535", "65535"};
      vecs[3] = '{16'd407,   1'b1, "  407", "00407"};
      vecs[4] = '{16'd9,     1'b0, "    9", "00009"};
      vecs[5] = '{16'd10,    1'b0, "   10", "00010"};
      vecs[6] = '{16'd10000, 1'b0, "10000", "10000"};
      vecs[7] = '{16'd50005, 1'b1, "50005", "50005"};
      vecs[8] = '{16'd100,   1'b0, "  100", "00100"};
      vecs[9] = '{16'd32768, 1'b0, "32768", "32768"};

      rst_n = 1'b0;
      fe    = 1'b1;
      data  = 16'h0;
      cr    = 1'b0;
      repeat (3) tick();
      chk("reset_char_out", 64'(if1.char_out), 64'h00);
      chk("reset_ctrl", 64'({if1.rd, if1.char_valid, if1.token_done, if1.busy}), 64'd0);
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (if1.rd || if1.char_valid || if1.token_done || if1.busy || if1.char_out != 8'h00) bad++;
      end
      chk("idle_while_empty", 64'(bad), 64'd0);

      for (int i = 0; i < 10; i++) begin
         run_one(vecs[i]);
         repeat (2) tick();
      end

      clear_obs();
      cr = 1'b1;
      fifo.push_back(16'd7);
      fifo.push_back(16'd100);
      fifo.push_back(16'd40000);
      fe = 1'b0;
      wait_done(3, 1'b0);
      repeat (10) tick();
      chk("three_rd", 64'(rd_cnt), 64'd3);
      chk("three_tok0", 64'(pack(1'b1, 0)), 64'("    7"));
      chk("three_tok1", 64'(pack(1'b1, 5)), 64'("  100"));
      chk("three_tok2", 64'(pack(1'b1, 10)), 64'("40000"));
      chk("three_nchars", 64'(got1.size()), 64'd15);

      clear_obs();
      fifo.push_back(16'd12345);
      fe = 1'b0;
      repeat (6) tick();
      abort_now("rst_conv");
      run_one('{16'd321, 1'b0, "  321", "00321"});

      clear_obs();
      cr = 1'b0;
      fifo.push_back(16'd999);
      fe = 1'b0;
      repeat (22) tick();
      chk("emit_stalled", 64'(if1.char_valid), 64'd1);
      abort_now("rst_emit");
      run_one('{16'd58, 1'b0, "   58", "00058"});

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
